gray_wptr_full: RTL and testbench

- Write-side pointer and flag generator for the asynchronous FIFO. It is the parametrised successor of the plain gray counter.
- Holds an (ADDR_W+1)-bit binary/gray write pointer and advances it only on accepted writes.
- Compares it against the read gray pointer, already synchronised into the write domain, to produce registered full, almost_full, fill level and a sticky overflow error.
- Sits in the write clock domain, between the producer and the FIFO RAM / 2-flop synchroniser.

---
 rtl/fifo_pkg.sv | 39 +++
 rtl/gray_wptr_full_if.sv | 26 ++
 rtl/gray2bin_w.sv | 14 +
 rtl/gray_wptr_full.sv | 85 ++++++++
 tb/tb_gray_wptr_full.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: depth derivation, gray
// conversion and the gray-domain full compare used by the write side.
package fifo_pkg;

  localparam int DEFAULT_ADDR_W = 4;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEFAULT_DEPTH = fifo_depth(DEFAULT_ADDR_W);

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] b;
    b        = '0;
    b[w-1]   = g[w-1];
    for (int i = w - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full when the write gray pointer equals the read gray pointer with its two
  // top bits inverted, i.e. exactly one lap (DEPTH entries) ahead.
  function automatic logic gray_full(input logic [31:0] wg,
                                     input logic [31:0] rg,
                                     input int          w);
    logic [31:0] mask;
    logic [31:0] flip;
    mask = (32'h1 << w) - 32'h1;
    flip = 32'h3 << (w - 2);
    return ((wg ^ rg ^ flip) & mask) == 32'h0;
  endfunction

endpackage

// File: rtl/gray_wptr_full_if.sv
// Producer-side bundle of the write pointer block: request, synchronised read
// pointer in; RAM address/enable, pointers and status flags out.
interface gray_wptr_full_if #(parameter int ADDR_W = 4);

  logic              winc;
  logic [ADDR_W:0]   rq2_rgray;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wbin;
  logic [ADDR_W:0]   wgray;
  logic              wen;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wlevel;
  logic              err_ovf;

  modport master (
    output winc, rq2_rgray,
    input  waddr, wbin, wgray, wen, full, almost_full, wlevel, err_ovf
  );

  modport slave (
    input  winc, rq2_rgray,
    output waddr, wbin, wgray, wen, full, almost_full, wlevel, err_ovf
  );

endinterface

// File: rtl/gray2bin_w.sv
// Combinational gray-to-binary decoder: each binary bit is the XOR of all
// gray bits at and above it.
module gray2bin_w #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/gray_wptr_full.sv
// Write-domain pointer and flag generator for the async FIFO: advances the
// binary/gray write pointer on accepted writes and derives full/level flags.
module gray_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  gray_wptr_full_if.slave  wif
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wgray_q;
  logic [PW-1:0] wlevel_q;
  logic          full_q;
  logic          almost_full_q;
  logic          err_ovf_q;

  logic          wen;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          almost_full_next;

  gray2bin_w #(.W(PW)) u_rdec (
    .gray (wif.rq2_rgray),
    .bin  (rbin_s)
  );

  assign wen = wif.winc & ~full_q;

  // Flags are computed from the post-write pointer so a write and a read
  // pointer update landing on the same edge are folded together.
  always_comb begin
    wbin_next        = wbin_q + {{ADDR_W{1'b0}}, wen};
    wgray_next       = PW'(bin2gray(32'(wbin_next)));
    level_next       = wbin_next - rbin_s;
    full_next        = gray_full(32'(wgray_next), 32'(wif.rq2_rgray), PW);
    almost_full_next = (level_next >= PW'(DEPTH - AF_MARGIN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q        <= '0;
      wgray_q       <= '0;
      wlevel_q      <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      wbin_q        <= wbin_next;
      wgray_q       <= wgray_next;
      wlevel_q      <= level_next;
      full_q        <= full_next;
      almost_full_q <= almost_full_next;
      err_ovf_q     <= err_ovf_q | (wif.winc & full_q);
    end
  end

  assign wif.waddr       = wbin_q[ADDR_W-1:0];
  assign wif.wbin        = wbin_q;
  assign wif.wgray       = wgray_q;
  assign wif.wen         = wen;
  assign wif.full        = full_q;
  assign wif.almost_full = almost_full_q;
  assign wif.wlevel      = wlevel_q;
  assign wif.err_ovf     = err_ovf_q;

`ifndef SYNTHESIS
  // A level beyond DEPTH means the read pointer was illegal (ahead or too far back).
  always @(posedge clk) begin
    if (!rst) begin
      assert (wlevel_q <= PW'(DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_gray_wptr_full.sv
// Randomised and directed checks of gray_wptr_full against a count-based
// model of the FIFO occupancy (total writes accepted vs total reads seen).
module tb_gray_wptr_full;

  localparam int ADDR_W    = 3;
  localparam int AF_MARGIN = 2;
  localparam int DEPTH     = 8;
  localparam int PTR_MOD   = 16;

  logic clk;
  logic rst;

  int compared   = 0;
  int mismatched = 0;

  int m_wr;
  int m_rd;
  bit m_full;
  bit m_err;

  gray_wptr_full_if #(.ADDR_W(ADDR_W)) wif ();

  gray_wptr_full #(
    .ADDR_W    (ADDR_W),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wif (wif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input int count);
    int b;
    b = count % PTR_MOD;
    return 4'(b ^ (b >> 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, check wen, take the rising
  // edge, advance the model and compare every registered output.
  task automatic applyStimulus(input bit w, input bit rs, input int rd_new);
    int level;
    @(negedge clk);
    wif.winc      = w;
    rst           = rs;
    wif.rq2_rgray = to_gray(rd_new);
    #1;
    checkOutput("wen", 32'(wif.wen), 32'(w & ~m_full));
    @(posedge clk);
    if (rs) begin
      m_wr   = 0;
      m_rd   = 0;
      m_full = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (w && m_full) m_err = 1'b1;
      if (w && !m_full) m_wr++;
      m_rd   = rd_new;
      m_full = ((m_wr - m_rd) == DEPTH);
    end
    level = m_wr - m_rd;
    #1;
    checkOutput("wbin",        32'(wif.wbin),        32'(m_wr % PTR_MOD));
    checkOutput("waddr",       32'(wif.waddr),       32'(m_wr % DEPTH));
    checkOutput("wgray",       32'(wif.wgray),       32'(to_gray(m_wr)));
    checkOutput("wlevel",      32'(wif.wlevel),      32'(level));
    checkOutput("full",        32'(wif.full),        32'(m_full));
    checkOutput("almost_full", 32'(wif.almost_full), 32'(level >= DEPTH - AF_MARGIN));
    checkOutput("err_ovf",     32'(wif.err_ovf),     32'(m_err));
  endtask

  initial begin
    int  rd_next;
    bit  w;
    int  wprob;
    int  prev_bin;

    m_wr = 0; m_rd = 0; m_full = 1'b0; m_err = 1'b0;
    rst           = 1'b1;
    wif.winc      = 1'b1;
    wif.rq2_rgray = 4'b0110;

    // Reset with activity on the inputs
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wbin",   32'(wif.wbin),        32'd0);
    checkOutput("rst_wgray",  32'(wif.wgray),       32'd0);
    checkOutput("rst_full",   32'(wif.full),        32'd0);
    checkOutput("rst_af",     32'(wif.almost_full), 32'd0);
    checkOutput("rst_wlevel", 32'(wif.wlevel),      32'd0);
    checkOutput("rst_err",    32'(wif.err_ovf),     32'd0);

    // Fill from empty
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 0);
      if (i == 6) begin
        checkOutput("fill6_level", 32'(wif.wlevel),      32'd6);
        checkOutput("fill6_af",    32'(wif.almost_full), 32'd1);
      end
    end
    checkOutput("fill8_wbin",  32'(wif.wbin),   32'd8);
    checkOutput("fill8_wgray", 32'(wif.wgray),  32'b1100);
    checkOutput("fill8_full",  32'(wif.full),   32'd1);
    checkOutput("fill8_level", 32'(wif.wlevel), 32'd8);
    checkOutput("fill8_waddr", 32'(wif.waddr),  32'd0);

    // Writes while full
    repeat (3) applyStimulus(1'b1, 1'b0, 0);
    checkOutput("ovf_wbin", 32'(wif.wbin),    32'd8);
    checkOutput("ovf_err",  32'(wif.err_ovf), 32'd1);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("ovf_sticky", 32'(wif.err_ovf), 32'd1);

    // Drain three entries in one step
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("drain_full",  32'(wif.full),        32'd0);
    checkOutput("drain_level", 32'(wif.wlevel),      32'd5);
    checkOutput("drain_af",    32'(wif.almost_full), 32'd0);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("drain_wr_wbin", 32'(wif.wbin), 32'd9);

    // Alternate writes and reads across the pointer wrap
    prev_bin = m_wr % PTR_MOD;
    while (m_wr < 18) begin
      applyStimulus(1'b1, 1'b0, m_rd);
      applyStimulus(1'b0, 1'b0, (m_rd < m_wr) ? m_rd + 1 : m_rd);
      if (prev_bin == 15 && (m_wr % PTR_MOD) == 0) begin
        checkOutput("wrap_wgray", 32'(wif.wgray), 32'd0);
        checkOutput("wrap_waddr", 32'(wif.waddr), 32'd0);
      end
      prev_bin = m_wr % PTR_MOD;
    end

    // Mid-operation reset at wbin=5 with the overflow flag set
    while ((m_wr % PTR_MOD) != 5)
      applyStimulus(1'b1, 1'b0, (m_rd < m_wr) ? m_rd + 1 : m_rd);
    checkOutput("pre_rst_err", 32'(wif.err_ovf), 32'd1);
    applyStimulus(1'b1, 1'b1, m_rd);
    checkOutput("mid_rst_wbin", 32'(wif.wbin),    32'd0);
    checkOutput("mid_rst_err",  32'(wif.err_ovf), 32'd0);
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("post_rst_wbin",  32'(wif.wbin),  32'd1);
    checkOutput("post_rst_wgray", 32'(wif.wgray), 32'b0001);

    // Random traffic with write-heavy and read-heavy phases
    wprob = 80;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ((cyc % 50) == 0) wprob = (($urandom % 2) == 0) ? 85 : 25;
      w = ($urandom_range(99) < wprob);
      rd_next = m_rd;
      if (rd_next < m_wr && ($urandom_range(99) >= wprob)) rd_next = rd_next + 1;
      if ($urandom_range(99) == 0) applyStimulus(w, 1'b1, rd_next);
      else                         applyStimulus(w, 1'b0, rd_next);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
